// File: rtl/max7219_pkg.sv
// Shared MAX7219 register map and word layout, used by both the driver and the receiver.
package max7219_pkg;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int WORD_BITS  = 16;
  localparam int NUM_DIGITS = 8;
  localparam int CNT_W      = 5;

  localparam logic [ADDR_W-1:0] REG_NOOP        = 4'h0;
  localparam logic [ADDR_W-1:0] REG_DIGIT1      = 4'h1;
  localparam logic [ADDR_W-1:0] REG_DIGIT8      = 4'h8;
  localparam logic [ADDR_W-1:0] REG_DECODE_MODE = 4'h9;
  localparam logic [ADDR_W-1:0] REG_INTENSITY   = 4'hA;
  localparam logic [ADDR_W-1:0] REG_SCAN_LIMIT  = 4'hB;
  localparam logic [ADDR_W-1:0] REG_SHUTDOWN    = 4'hC;
  localparam logic [ADDR_W-1:0] REG_DISP_TEST   = 4'hF;

  // Low 12 bits of a frame; the top nibble is don't-care and never stored.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } word_t;

  function automatic logic is_digit(logic [ADDR_W-1:0] addr);
    return (addr >= REG_DIGIT1) && (addr <= REG_DIGIT8);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/max7219_rx.sv
// Receives MAX7219 serial frames from an external driver and mirrors its register file.
module max7219_rx
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_in,
  input  logic        data_in,
  input  logic        load,
  output logic        word_valid,
  output logic [3:0]  word_addr,
  output logic [7:0]  word_data,
  output logic        err_len,
  output logic [63:0] digits,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        disp_test,
  output logic        frame_done
);

  logic clk_s, data_s, load_s;
  logic clk_d, data_d, load_d;
  logic clk_rise_q, load_rise_q, load_fall_q;
  logic [CNT_W-1:0]      bit_cnt;
  word_t                 shift;
  logic [NUM_DIGITS-1:0] bitmap, digit_mask, bitmap_next;
  logic [2:0]            digit_idx;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk  (.clk(clk), .rst_n(rst_n), .d(clk_in),  .q(clk_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (.clk(clk), .rst_n(rst_n), .d(data_in), .q(data_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (.clk(clk), .rst_n(rst_n), .d(load),    .q(load_s));

  // Edges are registered; the *_d copies are then the signal levels aligned with those edge flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_d       <= 1'b0;
      data_d      <= 1'b0;
      load_d      <= 1'b0;
      clk_rise_q  <= 1'b0;
      load_rise_q <= 1'b0;
      load_fall_q <= 1'b0;
    end else begin
      clk_d       <= clk_s;
      data_d      <= data_s;
      load_d      <= load_s;
      clk_rise_q  <= clk_s & ~clk_d;
      load_rise_q <= load_s & ~load_d;
      load_fall_q <= ~load_s & load_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || load_fall_q) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (clk_rise_q && !load_d) begin
      shift <= {shift[$bits(word_t)-2:0], data_d};
      if (bit_cnt != CNT_W'(WORD_BITS + 1)) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    digit_idx   = 3'(shift.addr - 4'd1);
    digit_mask  = '0;
    if (is_digit(shift.addr)) digit_mask = 8'b1 << digit_idx;
    bitmap_next = bitmap | digit_mask;
  end

  // NOTE: the register file is a handful of flops, so it is reset outright rather than left undefined.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_valid  <= 1'b0;
      err_len     <= 1'b0;
      frame_done  <= 1'b0;
      word_addr   <= '0;
      word_data   <= '0;
      bitmap      <= '0;
      digits      <= '0;
      decode_mode <= '0;
      intensity   <= '0;
      scan_limit  <= '0;
      shutdown_n  <= 1'b0;
      disp_test   <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      err_len    <= 1'b0;
      frame_done <= 1'b0;
      if (load_rise_q) begin
        if (bit_cnt == CNT_W'(WORD_BITS)) begin
          word_valid <= 1'b1;
          word_addr  <= shift.addr;
          word_data  <= shift.data;
          if (is_digit(shift.addr)) begin
            digits[{digit_idx, 3'b000} +: 8] <= shift.data;
            if (&bitmap_next) begin
              frame_done <= 1'b1;
              bitmap     <= '0;
            end else begin
              bitmap <= bitmap_next;
            end
          end else begin
            case (shift.addr)
              REG_DECODE_MODE: decode_mode <= shift.data;
              REG_INTENSITY:   intensity   <= shift.data[3:0];
              REG_SCAN_LIMIT:  scan_limit  <= shift.data[2:0];
              REG_SHUTDOWN:    shutdown_n  <= shift.data[0];
              REG_DISP_TEST:   disp_test   <= shift.data[0];
              default: ;
            endcase
          end
        end else begin
          err_len <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_max7219_rx.sv
// Directed plus random frames against a register-file reference model of the MAX7219 receiver.
module tb_max7219_rx;

  localparam int S = 2;

  logic        clk = 1'b0, rst_n = 1'b0, clk_in = 1'b0, data_in = 1'b0, load = 1'b1;
  logic        word_valid, err_len, frame_done, shutdown_n, disp_test;
  logic [3:0]  word_addr, intensity;
  logic [7:0]  word_data, decode_mode;
  logic [2:0]  scan_limit;
  logic [63:0] digits;

  int total = 0, bad = 0;

  // Reference model state
  logic [63:0] m_digits;
  logic [7:0]  m_decode, m_data, m_seen;
  logic [3:0]  m_int, m_addr;
  logic [2:0]  m_scan;
  logic        m_shut, m_test;

  max7219_rx #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .data_in(data_in), .load(load),
    .word_valid(word_valid), .word_addr(word_addr), .word_data(word_data),
    .err_len(err_len), .digits(digits), .decode_mode(decode_mode),
    .intensity(intensity), .scan_limit(scan_limit), .shutdown_n(shutdown_n),
    .disp_test(disp_test), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_digits = '0; m_decode = '0; m_data = '0; m_seen = '0;
    m_int = '0; m_addr = '0; m_scan = '0; m_shut = 1'b0; m_test = 1'b0;
  endtask

  task automatic check_regs(string tag);
    check({tag, ".digits"},      digits,      m_digits);
    check({tag, ".decode_mode"}, decode_mode, m_decode);
    check({tag, ".intensity"},   intensity,   m_int);
    check({tag, ".scan_limit"},  scan_limit,  m_scan);
    check({tag, ".shutdown_n"},  shutdown_n,  m_shut);
    check({tag, ".disp_test"},   disp_test,   m_test);
    check({tag, ".word_addr"},   word_addr,   m_addr);
    check({tag, ".word_data"},   word_data,   m_data);
  endtask

  task automatic shift_bits(logic [31:0] val, int nbits);
    load = 1'b0;
    hold(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      data_in = val[i];
      hold(3);
      clk_in = 1'b1;
      hold(3);
      clk_in = 1'b0;
    end
  endtask

  // Raises load, watches the response window, then updates the model and compares.
  task automatic raise_load(string tag, logic [31:0] val, int nbits);
    int wv = 0, el = 0, fd = 0, lat = -1;
    logic exp_fd = 1'b0;
    int a;
    hold(2);
    load = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (word_valid === 1'b1) wv++;
      if (err_len === 1'b1) el++;
      if (frame_done === 1'b1) fd++;
      if ((word_valid === 1'b1 || err_len === 1'b1) && lat < 0) lat = j;
    end
    if (nbits == 16) begin
      a = int'(val[11:8]);
      m_addr = val[11:8];
      m_data = val[7:0];
      if (a >= 1 && a <= 8) begin
        m_digits[8*a-8 +: 8] = val[7:0];
        m_seen[a-1] = 1'b1;
        if (m_seen == 8'hFF) begin
          exp_fd = 1'b1;
          m_seen = '0;
        end
      end else if (a == 9)  m_decode = val[7:0];
      else if (a == 10) m_int  = val[3:0];
      else if (a == 11) m_scan = val[2:0];
      else if (a == 12) m_shut = val[0];
      else if (a == 15) m_test = val[0];
    end
    check({tag, ".word_valid_cycles"}, 64'(wv), (nbits == 16) ? 64'd1 : 64'd0);
    check({tag, ".err_len_cycles"},    64'(el), (nbits == 16) ? 64'd0 : 64'd1);
    check({tag, ".frame_done_cycles"}, 64'(fd), 64'(exp_fd));
    check({tag, ".latency"},           64'(lat), 64'(S + 2));
    check_regs(tag);
  endtask

  task automatic send_word(string tag, logic [31:0] val, int nbits);
    shift_bits(val, nbits);
    raise_load(tag, val, nbits);
  endtask

  initial begin
    logic [7:0] dig_data [8] = '{8'h0C, 8'h0E, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h3F, 8'h00};
    logic [31:0] v;
    int n;

    model_reset();
    hold(3);
    check("reset.word_valid", word_valid, 1'b0);
    check("reset.err_len",    err_len,    1'b0);
    check("reset.frame_done", frame_done, 1'b0);
    check_regs("reset");
    rst_n = 1'b1;
    hold(10);

    send_word("shutdown", 32'h0C01, 16);
    check("shutdown.on", shutdown_n, 1'b1);

    send_word("intensity", 32'h0A00, 16);
    send_word("scan",      32'h0B07, 16);
    send_word("decode",    32'h0900, 16);

    for (int k = 1; k <= 8; k++)
      send_word($sformatf("digit%0d", k), {20'h0, 4'(k), dig_data[k-1]}, 16);
    check("frame.digits_literal", digits, 64'h003F0C0C0C0C0E0C);

    send_word("short15", 32'h0000_1234, 15);
    send_word("long20",  32'h000F_0C00, 20);
    send_word("dup_digit_a", 32'h0311, 16);
    send_word("dup_digit_b", 32'h0322, 16);

    shift_bits(32'h0155, 8);
    rst_n = 1'b0;
    hold(2);
    model_reset();
    check("midreset.word_valid", word_valid, 1'b0);
    check("midreset.err_len",    err_len,    1'b0);
    check_regs("midreset");
    rst_n = 1'b1;
    hold(3);
    raise_load("post_reset_rise", 32'h0, 0);
    send_word("after_reset", 32'h0155, 16);
    check("after_reset.digit1", digits[7:0], 8'h55);

    send_word("disp_test", 32'h0F01, 16);
    check("disp_test.on", disp_test, 1'b1);
    send_word("noop", 32'h0000, 16);
    send_word("noop_d", 32'hA0D5, 16);

    for (int r = 0; r < 40; r++) begin
      v = $urandom;
      n = ($urandom_range(0, 3) != 0) ? 16 : int'($urandom_range(1, 20));
      send_word($sformatf("rand%0d", r), v, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/max7219_rx.md
MAX7219_RX -- requirements
Module: max7219_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the number of flip-flops in each input synchronizer (minimum 2).
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 clk_in  input  1  asynchronous serial clock from the display driver.
REQ-005 data_in  input  1  asynchronous serial data, MSB first.
REQ-006 load  input  1  asynchronous frame strobe; low while a word is shifted, rising edge latches the word.
REQ-007 word_valid  output  1  one-cycle pulse when a 16-bit word is committed.
REQ-008 word_addr  output  4  address nibble of the last committed word.
REQ-009 word_data  output  8  data byte of the last committed word.
REQ-010 err_len  output  1  one-cycle pulse when load rises with a bit count other than 16.
REQ-011 digits  output  64  digit registers; digit k (1..8) occupies bits [8k-1:8k-8].
REQ-012 decode_mode  output  8  register 0x9.
REQ-013 intensity  output  4  register 0xA, bits [3:0].
REQ-014 scan_limit  output  3  register 0xB, bits [2:0].
REQ-015 shutdown_n  output  1  register 0xC bit 0; 0 = shutdown.
REQ-016 disp_test  output  1  register 0xF bit 0.
REQ-017 frame_done  output  1  one-cycle pulse when all eight digit registers have been written since the previous pulse.

Function
REQ-018 clk_in, data_in and load each pass through a SYNC_STAGES synchronizer; edges are detected on the synchronized signals against a one-cycle-delayed copy.
REQ-019 A synchronized load falling edge clears the bit counter and the shift register.
REQ-020 A synchronized clk_in rising edge, while synchronized load is low, shifts synchronized data_in into the shift register LSB and increments the bit counter, saturating at 17.
REQ-021 A clk_in rising edge in a cycle where synchronized load is high is ignored; this includes the cycle in which the load rising edge is detected.
REQ-022 On a synchronized load rising edge with bit counter == 16, the next cycle asserts word_valid, updates word_addr = shift[11:8] and word_data = shift[7:0], and writes the addressed register in that same cycle.
REQ-023 On a synchronized load rising edge with bit counter != 16, the next cycle asserts err_len; no register, word_addr or word_data changes.
REQ-024 Latency from a raw load rise to word_valid or err_len is SYNC_STAGES+2 clk cycles.
REQ-025 Address map: 0x0 no-op; 0x1-0x8 digit 1-8; 0x9 decode_mode; 0xA intensity; 0xB scan_limit; 0xC shutdown_n; 0xF disp_test; 0xD and 0xE no-op. Bits [15:12] are ignored.
REQ-026 A no-op address still pulses word_valid.
REQ-027 An 8-bit written-digit bitmap sets bit k-1 on each digit-k write. The write that completes the bitmap pulses frame_done in the same cycle as word_valid and clears the bitmap.
REQ-028 Rewriting an already-set digit before the bitmap completes does not pulse frame_done.
REQ-029 word_valid, err_len and frame_done are never asserted for more than one consecutive cycle.

Reset
REQ-030 While rst_n is low at a clk edge, the following are cleared: synchronizers, bit counter, shift register, bitmap, digits, decode_mode, intensity, scan_limit, word_addr, word_data, disp_test, and all pulses. shutdown_n resets to 0.
REQ-031 Reset mid-word discards the partial word. A load rise after reset with no intervening load fall produces err_len.

Structure
REQ-032 The register address constants (0x0-0xF) and the field widths belong in a shared package, max7219_pkg, which the driver also uses.
REQ-033 The synchronizer is a sub-module, sync_ff, parameterized by SYNC_STAGES and instantiated three times.

Verification
REQ-034 Reset, then send word 0x0C01 -> word_valid once, word_addr=0xC, word_data=0x01, shutdown_n=1.
REQ-035 Send 0x0A00, 0x0B07, 0x0900 -> intensity=0, scan_limit=7, decode_mode=0x00; frame_done stays 0.
REQ-036 Send digits 0x01..0x08 with data 0x0C,0x0E,0x0C,0x0C,0x0C,0x0C,0x3F,0x00 -> digits=0x003F0C0C0C0C0E0C; frame_done pulses exactly once, on the 0x08 write.
REQ-037 Shift 15 bits then raise load -> err_len pulses once, word_valid stays 0, registers unchanged. Repeat with 20 bits -> same response.
REQ-038 Assert rst_n low after 8 bits of 0x0155 -> all outputs return to reset values; the following complete word 0x0155 sets digits[7:0]=0x55.
REQ-039 Send 0x0F01, then 0x0000 -> disp_test=1, then a word_valid pulse for the no-op with all registers unchanged.
